execid_reorder: RTL and testbench
=================================

# execid_reorder

Runtime reorder buffer that sits on the consuming side of execution-ID-tagged traffic. Parallel or pipelined producers emit results tagged with a flat execution ID, possibly out of order. This block buffers them and releases them strictly in increasing-ID order. It is the receiver counterpart to the EXECID_INC sequencing primitives: it keeps the expected-next ID counter in hardware and advances it once per released item.

## Interface
- WIDTH, 8: payload data width in bits.
- ID_WIDTH, 8: execution-ID width; IDs wrap modulo 2^ID_WIDTH.
- DEPTH, 4: reorder window in entries; must be a power of two and ≤ 2^(ID_WIDTH-1).

- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  producer presents an item.
- IN_READY  output  1  block accepts the item this cycle.
- IN_ID  input  ID_WIDTH  execution ID of the item.
- IN_DATA  input  WIDTH  payload.
- OUT_VALID  output  1  head item available.
- OUT_READY  input  1  consumer takes the head item.
- OUT_ID  output  ID_WIDTH  ID of the head item; always equals HEAD_ID.
- OUT_DATA  output  WIDTH  payload of the head item.
- ERR  output  1  sticky flag: a stale or duplicate ID was received.

## Operation
- State:
  - HEAD_ID (ID_WIDTH): next ID to release.
  - occ[DEPTH]: occupancy bits.
  - mem[DEPTH] × WIDTH: payload storage.
  - ERR flop.
- Slot index = ID mod DEPTH (low log2(DEPTH) bits).
- off = (IN_ID − HEAD_ID) mod 2^ID_WIDTH, computed from the registered HEAD_ID (pre-pop value).
- IN_ID classification:
  - window: off < DEPTH.
  - stale: off ≥ 2^(ID_WIDTH-1).
  - future: otherwise.
- IN_READY = ¬RST ∧ ¬future. It depends only on IN_ID and registered state, not on OUT_READY.
- Accept (IN_VALID ∧ IN_READY):
  - window and occ[slot]=0: write mem[slot], set occ[slot].
  - window and occ[slot]=1 (duplicate): drop the payload, set ERR.
  - stale: drop the payload, set ERR.
- OUT_VALID = occ[HEAD_ID mod DEPTH]; OUT_DATA = mem[that slot]; OUT_ID = HEAD_ID.
- Pop (OUT_VALID ∧ OUT_READY): clear occ[head slot], HEAD_ID ← HEAD_ID+1 (wraps to 0 after all-ones).
- Pop and write in the same cycle:
  - Both take effect.
  - A write can never target the head slot with a new ID, because off=DEPTH is classified future.
  - A write with off=0 while the head is occupied is a duplicate.
- ERR stays set until RST.

## Timing
- Reset values: HEAD_ID=0, occ=0, ERR=0. Therefore OUT_VALID=0, OUT_ID=0, OUT_DATA=0 (mem is cleared on reset), and IN_READY=0 while RST is high.
- Latency: an item accepted at edge N with off=0 gives OUT_VALID=1 in the cycle after edge N. No combinational path from IN_* to OUT_*.
- Throughput: one accept and one release per cycle, sustained.
- OUT_VALID/OUT_DATA are held stable until popped (AXI-style). The producer must hold IN_* while IN_VALID ∧ ¬IN_READY.
- RST mid-operation: all buffered items are discarded and HEAD_ID returns to 0 on the next edge. Inputs presented during RST are ignored.

## Structure
- Shared package/header: ID offset function (modular subtract), window classification encoding (WINDOW/STALE/FUTURE), and the DEPTH legality check. EXECID primitive models reuse these.
- One sub-module, execid_reorder_slots: mem + occ array with one write port, one clear port and one read port. The top level holds HEAD_ID, classification, handshake and ERR.
- Elaboration must fail if DEPTH is not a power of two or DEPTH > 2^(ID_WIDTH-1).

## Test plan
- In-order: IDs 0,1,2,3 with data A0..A3, OUT_READY=1 → out IDs 0..3 in order, one per cycle, each one cycle after its accept; ERR=0.
- Out-of-order: IDs 2,0,3,1 (DEPTH=4) → OUT_VALID rises only after ID 0 is accepted; output order is 0,1,2,3 with matching data.
- Window full: HEAD_ID=0, IDs 0..3 buffered, OUT_READY=0, present ID 4 → IN_READY=0. Pop one item → ID 4 is accepted the next cycle.
- Wrap: ID_WIDTH=3, DEPTH=4, stream IDs 0..7 then 0,1 in order → HEAD_ID wraps 7→0 and both 0s are released; ERR=0.
- Errors:
  - After releasing ID 5, send ID 3 → accepted, dropped, ERR=1, outputs unchanged.
  - Send ID 6 twice → second copy dropped, ERR=1, first payload released.
- Reset mid-stream: 2 items buffered, assert RST for 1 cycle → OUT_VALID=0, ERR=0, HEAD_ID=0; ID 0 then releases normally.

Source files
------------

// File: rtl/execid_reorder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : execid_reorder_pkg
//  Description : Shared execution-ID helpers: modular offset, window
//                classification and reorder-depth legality.
//  Revision    : 1.0 - initial release
// ============================================================================
package execid_reorder_pkg;

    typedef enum logic [1:0] {
        CLS_WINDOW = 2'd0,
        CLS_STALE  = 2'd1,
        CLS_FUTURE = 2'd2
    } win_class_e;

    function automatic logic [31:0] id_mask(input int unsigned id_width);
        return (id_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << id_width) - 32'd1);
    endfunction

    // (id - head) mod 2^id_width
    function automatic logic [31:0] id_offset(input logic [31:0] id,
                                              input logic [31:0] head,
                                              input int unsigned id_width);
        return (id - head) & id_mask(id_width);
    endfunction

    // Offsets in the upper half of the ID space lie behind the head.
    function automatic win_class_e id_classify(input logic [31:0] off,
                                               input logic [31:0] depth,
                                               input int unsigned id_width);
        win_class_e cls;
        if (off < depth)
            cls = CLS_WINDOW;
        else if (off >= (32'd1 << (id_width - 1)))
            cls = CLS_STALE;
        else
            cls = CLS_FUTURE;
        return cls;
    endfunction

    function automatic bit depth_legal(input logic [31:0] depth,
                                       input int unsigned id_width);
        return (depth != 32'd0)
            && ((depth & (depth - 32'd1)) == 32'd0)
            && (id_width >= 1) && (id_width <= 32)
            && (depth <= (32'd1 << (id_width - 1)));
    endfunction

endpackage : execid_reorder_pkg
`default_nettype wire

// File: rtl/execid_reorder_slots.sv
`default_nettype none
// ============================================================================
//  Module      : execid_reorder_slots
//  Description : Payload storage plus occupancy bits; one write, one clear
//                and one read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module execid_reorder_slots #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SLOT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_slot,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              clr_en,
    input  logic [SLOT_W-1:0] clr_slot,
    input  logic [SLOT_W-1:0] rd_slot,
    output logic              rd_valid,
    output logic [WIDTH-1:0]  rd_data,
    output logic [DEPTH-1:0]  occ
);

    logic [DEPTH-1:0] r_occ;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // A write never lands on the slot being cleared with a new ID, so the
    // statement order below only matters for the impossible case.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (clr_en) begin
                r_occ[clr_slot] <= 1'b0;
            end
            if (wr_en) begin
                r_occ[wr_slot] <= 1'b1;
                r_mem[wr_slot] <= wr_data;
            end
        end
    end

    assign rd_valid = r_occ[rd_slot];
    assign rd_data  = r_mem[rd_slot];
    assign occ      = r_occ;

endmodule : execid_reorder_slots
`default_nettype wire

// File: rtl/execid_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : execid_reorder
//  Description : Reorder buffer releasing execution-ID-tagged items strictly
//                in increasing-ID order; flags stale and duplicate IDs.
//  Revision    : 1.0 - initial release
// ============================================================================
module execid_reorder
    import execid_reorder_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ID_WIDTH = 8,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ID_WIDTH-1:0] in_id,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_WIDTH-1:0] out_id,
    output logic [WIDTH-1:0]    out_data,
    output logic                err
);

    localparam int unsigned        c_SLOT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ID_WIDTH-1:0] c_SLOT_MASK = ID_WIDTH'(DEPTH - 1);

    generate
        if (!depth_legal(32'(DEPTH), ID_WIDTH)) begin : g_depth_check
            $error("execid_reorder: DEPTH must be a power of two and <= 2^(ID_WIDTH-1)");
        end
    endgenerate

    logic [ID_WIDTH-1:0] r_head_id;
    logic                r_err;

    logic [ID_WIDTH-1:0] w_off;
    win_class_e          w_class;
    logic [c_SLOT_W-1:0] w_in_slot;
    logic [c_SLOT_W-1:0] w_head_slot;
    logic [DEPTH-1:0]    w_occ;
    logic                w_accept;
    logic                w_dup;
    logic                w_write;
    logic                w_bad;
    logic                w_pop;

    // Classification always uses the registered head, never the post-pop one.
    assign w_off       = ID_WIDTH'(id_offset(32'(in_id), 32'(r_head_id), ID_WIDTH));
    assign w_class     = id_classify(32'(w_off), 32'(DEPTH), ID_WIDTH);
    assign w_in_slot   = c_SLOT_W'(in_id & c_SLOT_MASK);
    assign w_head_slot = c_SLOT_W'(r_head_id & c_SLOT_MASK);

    assign in_ready = !rst && (w_class != CLS_FUTURE);
    assign w_accept = in_valid && in_ready;
    assign w_dup    = (w_class == CLS_WINDOW) && w_occ[w_in_slot];
    assign w_write  = w_accept && (w_class == CLS_WINDOW) && !w_occ[w_in_slot];
    assign w_bad    = w_accept && ((w_class == CLS_STALE) || w_dup);
    assign w_pop    = out_valid && out_ready;

    execid_reorder_slots #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .SLOT_W (c_SLOT_W)
    ) u_slots (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_write),
        .wr_slot  (w_in_slot),
        .wr_data  (in_data),
        .clr_en   (w_pop),
        .clr_slot (w_head_slot),
        .rd_slot  (w_head_slot),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .occ      (w_occ)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head_id <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head_id <= r_head_id + ID_WIDTH'(1);
            end
            if (w_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_id = r_head_id;
    assign err    = r_err;

endmodule : execid_reorder
`default_nettype wire

// File: tb/tb_execid_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execid_reorder
//  Description : Directed and randomized bench against an ID-indexed model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execid_reorder;

    localparam int c_W   = 8;
    localparam int c_IDW = 8;
    localparam int c_D   = 4;
    localparam int c_NID = 256;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [c_IDW-1:0] in_id = '0;
    logic [c_W-1:0] in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [c_IDW-1:0] out_id;
    logic [c_W-1:0] out_data;
    logic           err;

    always #5 clk = ~clk;

    execid_reorder #(
        .WIDTH    (c_W),
        .ID_WIDTH (c_IDW),
        .DEPTH    (c_D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_id     (in_id),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data),
        .err       (err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: items stored by absolute ID, head counts released items.
    int             m_head = 0;
    bit             m_have [c_NID];
    logic [c_W-1:0] m_data [c_NID];
    bit             m_err  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int offset_of(input int id);
        return (id - m_head + c_NID) % c_NID;
    endfunction

    function automatic bit model_ready(input bit r, input int id);
        int off;
        off = offset_of(id);
        return !r && ((off < c_D) || (off >= c_NID / 2));
    endfunction

    task automatic step(input bit r, input bit v, input int id_in,
                        input logic [c_W-1:0] d, input bit ordy);
        int id;
        int off;
        bit exp_rdy;
        bit acc;
        bit pop;
        id = id_in % c_NID;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_id     = c_IDW'(id);
        in_data   = d;
        out_ready = ordy;
        #1;
        off     = offset_of(id);
        exp_rdy = model_ready(r, id);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(out_valid), 32'(m_have[m_head]));
        chk("out_id", 32'(out_id), 32'(m_head));
        if (m_have[m_head]) begin
            chk("out_data", 32'(out_data), 32'(m_data[m_head]));
        end
        chk("err", 32'(err), 32'(m_err));
        acc = v && exp_rdy;
        pop = m_have[m_head] && ordy;
        @(posedge clk);
        if (r) begin
            foreach (m_have[i]) m_have[i] = 1'b0;
            m_head = 0;
            m_err  = 1'b0;
        end else begin
            if (acc) begin
                if ((off < c_D) && !m_have[id]) begin
                    m_have[id] = 1'b1;
                    m_data[id] = d;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (pop) begin
                m_have[m_head] = 1'b0;
                m_head = (m_head + 1) % c_NID;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic rand_run(input int n, input bit allow_err);
        bit             hold = 1'b0;
        int             hid = 0;
        logic [c_W-1:0] hd = '0;
        for (int k = 0; k < n; k++) begin
            bit r;
            bit v;
            int id;
            int off;
            int sel;
            logic [c_W-1:0] d;
            bit ordy;
            r    = allow_err && ($urandom_range(0, 99) < 2);
            ordy = ($urandom_range(0, 3) != 0);
            if (hold) begin
                v = 1'b1; id = hid; d = hd;
            end else begin
                sel = $urandom_range(0, 9);
                if (sel < 7)
                    off = $urandom_range(0, c_D - 1);
                else if (sel < 9 || !allow_err)
                    off = $urandom_range(c_D, c_D + 6);
                else
                    off = $urandom_range(c_NID / 2, c_NID - 1);
                id = (m_head + off) % c_NID;
                d  = c_W'($urandom);
                v  = ($urandom_range(0, 3) != 0);
                if (!allow_err && (off < c_D) && m_have[id]) v = 1'b0;
            end
            hold = !r && v && !model_ready(r, id);
            hid  = id;
            hd   = d;
            step(r, v, id, d, ordy);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        do_reset();
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // In-order stream
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, 8'hA0 + 8'(i), 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 0, '0, 1'b1);
        #1;
        chk("inorder_head", 32'(out_id), 32'd4);
        chk("inorder_err", 32'(err), 32'd0);

        // Out-of-order arrival
        do_reset();
        step(1'b0, 1'b1, 2, 8'hB2, 1'b1);
        #1;
        chk("ooo_wait", 32'(out_valid), 32'd0);
        step(1'b0, 1'b1, 0, 8'hB0, 1'b1);
        #1;
        chk("ooo_first_data", 32'(out_data), 32'hB0);
        step(1'b0, 1'b1, 3, 8'hB3, 1'b1);
        step(1'b0, 1'b1, 1, 8'hB1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, '0, 1'b1);
        #1;
        chk("ooo_head", 32'(out_id), 32'd4);

        // Window full back-pressure
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i, 8'hC0 + 8'(i), 1'b0);
        step(1'b0, 1'b1, 4, 8'hC4, 1'b0);
        #1;
        chk("full_ready", 32'(in_ready), 32'd0);
        step(1'b0, 1'b1, 4, 8'hC4, 1'b1);
        #1;
        chk("full_ready_after_pop", 32'(in_ready), 32'd1);
        step(1'b0, 1'b1, 4, 8'hC4, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 0, '0, 1'b1);
        #1;
        chk("full_head", 32'(out_id), 32'd5);

        // Stale ID
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i, 8'h10 + 8'(i), 1'b1);
        step(1'b0, 1'b0, 0, '0, 1'b1);
        step(1'b0, 1'b1, 3, 8'hEE, 1'b1);
        #1;
        chk("stale_err", 32'(err), 32'd1);
        chk("stale_out_valid", 32'(out_valid), 32'd0);
        chk("stale_out_id", 32'(out_id), 32'd6);

        // Duplicate ID
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, i, 8'h20 + 8'(i), 1'b1);
        step(1'b0, 1'b0, 0, '0, 1'b1);
        step(1'b0, 1'b1, 6, 8'h61, 1'b0);
        step(1'b0, 1'b1, 6, 8'h62, 1'b0);
        #1;
        chk("dup_err", 32'(err), 32'd1);
        chk("dup_data", 32'(out_data), 32'h61);
        step(1'b0, 1'b0, 0, '0, 1'b1);

        // Reset mid-stream
        do_reset();
        step(1'b0, 1'b1, 1, 8'h31, 1'b0);
        step(1'b0, 1'b1, 2, 8'h32, 1'b0);
        do_reset();
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_id", 32'(out_id), 32'd0);
        step(1'b0, 1'b1, 0, 8'h5A, 1'b0);
        #1;
        chk("midrst_release", 32'(out_data), 32'h5A);
        step(1'b0, 1'b0, 0, '0, 1'b1);

        // ID wrap-around
        do_reset();
        for (int i = 0; i < 260; i++) step(1'b0, 1'b1, i, 8'(i) ^ 8'h3C, 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 0, '0, 1'b1);
        #1;
        chk("wrap_head", 32'(out_id), 32'd4);
        chk("wrap_err", 32'(err), 32'd0);

        // Randomized traffic, error-free then with errors and resets
        do_reset();
        rand_run(1500, 1'b0);
        #1;
        chk("rand_clean_err", 32'(err), 32'd0);
        rand_run(1500, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_execid_reorder
`default_nettype wire
